// File: rtl/vram_arb_if.sv
// Bus bundle between the pixel pipeline, the two renderers and the VRAM macro.
// The arbiter sits on the slave modport; the surrounding system uses master.
interface vram_arb_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 12
);
   logic              blank;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic [1:0]        wr_req;
   logic [ADDR_W-1:0] wr_addr0;
   logic [ADDR_W-1:0] wr_addr1;
   logic [DATA_W-1:0] wr_data0;
   logic [DATA_W-1:0] wr_data1;
   logic [1:0]        wr_gnt;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  blank, rd_req, rd_addr,
      input  wr_req, wr_addr0, wr_addr1,
      input  wr_data0, wr_data1, mem_rdata,
      output rd_data, rd_valid, wr_gnt,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output blank, rd_req, rd_addr,
      output wr_req, wr_addr0, wr_addr1,
      output wr_data0, wr_data1, mem_rdata,
      input  rd_data, rd_valid, wr_gnt,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display reads win every cycle, two writers share the rest
// round-robin with bounded bursts. Define VRAM_ARB_STATS_EN for grant/stall counters.
module vram_arbiter #(
   parameter int ADDR_W        = 17,
   parameter int DATA_W        = 12,
   parameter int MAX_BURST     = 8,
   parameter int WR_BLANK_ONLY = 1
) (
   input  logic        clk,
   input  logic        reset,
`ifdef VRAM_ARB_STATS_EN
   input  logic        stats_clr,
   output logic [15:0] gnt_cnt0,
   output logic [15:0] gnt_cnt1,
   output logic [15:0] stall_cnt,
`endif
   vram_arb_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] MAXB = 8'(MAX_BURST);

   state_t      state, state_n;
   logic        rr_ptr, rr_ptr_n;
   logic [7:0]  burst_cnt, burst_cnt_n;
   logic [1:0]  gnt;
   logic        pick;
   logic        own;
   logic        write_ok;
   logic        rd_v1, rd_v2;

   assign write_ok = !bus.rd_req && (bus.blank || (WR_BLANK_ONLY == 0));
   assign own      = (state == OWN1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_ptr_n;
         burst_cnt <= burst_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      burst_cnt_n = burst_cnt;
      gnt         = '0;
      pick        = rr_ptr;
      unique case (state)
         IDLE: begin
            if (write_ok && (|bus.wr_req)) begin
               pick        = bus.wr_req[rr_ptr] ? rr_ptr : ~rr_ptr;
               gnt[pick]   = 1'b1;
               state_n     = pick ? OWN1 : OWN0;
               burst_cnt_n = 8'd1;
            end
         end
         OWN0, OWN1: begin
            if (!bus.wr_req[own]) begin
               // release hands the slot straight to the other writer
               state_n     = IDLE;
               rr_ptr_n    = ~own;
               burst_cnt_n = '0;
               pick        = ~own;
               if (write_ok && bus.wr_req[~own]) begin
                  gnt[pick]   = 1'b1;
                  state_n     = pick ? OWN1 : OWN0;
                  burst_cnt_n = 8'd1;
               end
            end else if (burst_cnt == MAXB) begin
               burst_cnt_n = '0;
               if (bus.wr_req[~own]) begin
                  pick     = ~own;
                  state_n  = pick ? OWN1 : OWN0;
                  rr_ptr_n = ~own;
                  if (write_ok) begin
                     gnt[pick]   = 1'b1;
                     burst_cnt_n = 8'd1;
                  end
               end
            end else if (write_ok) begin
               gnt[own]    = 1'b1;
               burst_cnt_n = burst_cnt + 8'd1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (reset) gnt = '0;
   end

   assign bus.wr_gnt = gnt;

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (bus.rd_req) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = bus.rd_addr;
      end else if (gnt[0]) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.wr_addr0;
         bus.mem_wdata = bus.wr_data0;
      end else if (gnt[1]) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = 1'b1;
         bus.mem_addr  = bus.wr_addr1;
         bus.mem_wdata = bus.wr_data1;
      end
   end

   // RAM output lands one cycle after the request; register it for a 2-cycle total
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_v1       <= 1'b0;
         rd_v2       <= 1'b0;
         bus.rd_data <= '0;
      end else begin
         rd_v1 <= bus.rd_req;
         rd_v2 <= rd_v1;
         if (rd_v1) bus.rd_data <= bus.mem_rdata;
      end
   end

   assign bus.rd_valid = rd_v2;

`ifdef VRAM_ARB_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gnt_cnt0  <= '0;
         gnt_cnt1  <= '0;
         stall_cnt <= '0;
      end else if (stats_clr) begin
         gnt_cnt0  <= '0;
         gnt_cnt1  <= '0;
         stall_cnt <= '0;
      end else begin
         if (gnt[0] && gnt_cnt0 != 16'hFFFF)
            gnt_cnt0 <= gnt_cnt0 + 16'd1;
         if (gnt[1] && gnt_cnt1 != 16'hFFFF)
            gnt_cnt1 <= gnt_cnt1 + 16'd1;
         if ((|bus.wr_req) && !(|gnt) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scenario bench for vram_arbiter: read latency, blank gating, round-robin
// bursts, display steal, release hand-off and reset mid-operation.
module tb_vram_arbiter;

   localparam int AW = 17;
   localparam int DW = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;

   vram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef VRAM_ARB_STATS_EN
   logic        stats_clr = 1'b0;
   logic [15:0] gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

   vram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4), .WR_BLANK_ONLY(1)
   ) dut (
      .clk(clk),
      .reset(reset),
`ifdef VRAM_ARB_STATS_EN
      .stats_clr(stats_clr),
      .gnt_cnt0(gnt_cnt0),
      .gnt_cnt1(gnt_cnt1),
      .stall_cnt(stall_cnt),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   localparam logic [AW-1:0] A0 = 17'h00080;
   localparam logic [AW-1:0] A1 = 17'h00090;
   localparam logic [DW-1:0] D0 = 12'h123;
   localparam logic [DW-1:0] D1 = 12'h456;

   // preloaded VRAM contents
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      if (a == 17'h00010) return 12'hABC;
      return 12'(a * 13 + 7);
   endfunction

   always @(posedge clk)
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= pat(bus.mem_addr);

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } rd_exp_t;

   rd_exp_t q[$];
   int cyc = 0;
   int errors = 0;
   int checks = 0;

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic sample();
      rd_exp_t e;
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected cyc=%0d got valid, want none", cyc);
         end else begin
            e = q.pop_front();
            if (e.cyc !== cyc || bus.rd_data !== e.data) begin
               errors++;
               $display("FAIL rd_data cyc=%0d data=%h want cyc=%0d data=%h",
                        cyc, bus.rd_data, e.cyc, e.data);
            end
         end
      end
   endtask

   task automatic idle_inputs();
      bus.blank    = 1'b0;
      bus.rd_req   = 1'b0;
      bus.rd_addr  = '0;
      bus.wr_req   = 2'b00;
      bus.wr_addr0 = A0;
      bus.wr_addr1 = A1;
      bus.wr_data0 = D0;
      bus.wr_data1 = D1;
   endtask

   task automatic drive_read(input logic [AW-1:0] a);
      rd_exp_t e;
      bus.rd_req  = 1'b1;
      bus.rd_addr = a;
      e.cyc  = cyc + 2;
      e.data = pat(a);
      q.push_back(e);
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      next_cycle();
   endtask

   task automatic drain();
      bus.rd_req = 1'b0;
      bus.wr_req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         sample();
         next_cycle();
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rd_missing left=%0d want 0", q.size());
         q.delete();
      end
   endtask

   task automatic check_gnt(input string nm, input logic [1:0] want);
      logic [AW-1:0] wa;
      checks++;
      if (bus.wr_gnt !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d gnt=%b want %b", nm, cyc, bus.wr_gnt, want);
      end
      if (want != 2'b00) begin
         wa = want[1] ? A1 : A0;
         checks++;
         if (bus.mem_we !== 1'b1 || bus.mem_addr !== wa) begin
            errors++;
            $display("FAIL %s_mem cyc=%0d we=%b addr=%h want we=1 addr=%h",
                     nm, cyc, bus.mem_we, bus.mem_addr, wa);
         end
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b11;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
         errors++;
         $display("FAIL reset_rd valid=%b data=%h want 0 000",
                  bus.rd_valid, bus.rd_data);
      end
      check_gnt("reset_gnt", 2'b00);
      apply_reset();
   endtask

   task automatic test_read_latency();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b01;
      drive_read(17'h00010);
      sample();
      check_gnt("rd_slot_gnt", 2'b00);
      checks++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00010) begin
         errors++;
         $display("FAIL rd_slot en=%b we=%b addr=%h want 1 0 00010",
                  bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      next_cycle();
      bus.rd_req = 1'b0;
      bus.wr_req = 2'b00;
      sample();
      next_cycle();
      sample();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 12'hABC) begin
         errors++;
         $display("FAIL rd_latency valid=%b data=%h want 1 abc",
                  bus.rd_valid, bus.rd_data);
      end
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         drive_read(17'h00020 + 17'(i));
         sample();
         next_cycle();
      end
      drain();
   endtask

   task automatic test_blank_gating();
      apply_reset();
      bus.wr_req = 2'b01;
      sample();
      check_gnt("blank0_gnt", 2'b00);
      checks++;
      if (bus.mem_en !== 1'b0 || bus.mem_addr !== '0) begin
         errors++;
         $display("FAIL blank0_mem en=%b addr=%h want 0 00000",
                  bus.mem_en, bus.mem_addr);
      end
      next_cycle();
      bus.blank = 1'b1;
      sample();
      check_gnt("blank1_gnt", 2'b01);
      checks++;
      if (bus.mem_wdata !== D0) begin
         errors++;
         $display("FAIL blank1_wdata got=%h want %h", bus.mem_wdata, D0);
      end
      next_cycle();
      drain();
   endtask

   task automatic test_round_robin();
      logic [1:0] want;
      apply_reset();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b11;
      for (int i = 0; i < 10; i++) begin
         want = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
         sample();
         check_gnt("rr_burst", want);
         next_cycle();
      end
      drain();
   endtask

   task automatic test_display_steal();
      logic [1:0] want;
      apply_reset();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b11;
      for (int i = 0; i < 8; i++) begin
         if (i >= 2 && i <= 4) drive_read(17'h00040 + 17'(i));
         else bus.rd_req = 1'b0;
         want = (i >= 2 && i <= 4) ? 2'b00 : (i == 7) ? 2'b10 : 2'b01;
         sample();
         check_gnt("steal", want);
         next_cycle();
      end
      drain();
   endtask

   task automatic test_release();
      apply_reset();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b11;
      for (int i = 0; i < 2; i++) begin
         sample();
         check_gnt("rel_own0", 2'b01);
         next_cycle();
      end
      bus.wr_req = 2'b10;
      for (int i = 0; i < 2; i++) begin
         sample();
         check_gnt("rel_handoff", 2'b10);
         next_cycle();
      end
      drain();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.blank  = 1'b1;
      bus.wr_req = 2'b10;
      sample();
      check_gnt("mid_own1", 2'b10);
      next_cycle();
      bus.wr_req = 2'b11;
      for (int i = 0; i < 2; i++) begin
         drive_read(17'h00030 + 17'(i));
         sample();
         check_gnt("mid_read", 2'b00);
         next_cycle();
      end
      bus.rd_req = 1'b0;
      reset = 1'b1;
      q.delete();
      #1;
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_async_valid got=%b want 0", bus.rd_valid);
      end
      sample();
      check_gnt("mid_in_reset", 2'b00);
      reset = 1'b0;
      next_cycle();
      sample();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_flushed_valid got=%b want 0", bus.rd_valid);
      end
      check_gnt("mid_after_reset", 2'b01);
      next_cycle();
      drain();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_read_latency();
      test_blank_gating();
      test_round_robin();
      test_display_steal();
      test_release();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port, synchronous-read video RAM between the display scan-out path and two game-logic writers (writer 0: sprite/alien renderer; writer 1: background/score renderer).
- Display reads have absolute priority and a fixed latency. Writers are arbitrated round-robin with bounded bursts.
- Sits between the VGA timing/pixel pipeline and the VRAM macro.

Parameters:
- ADDR_W, 17, VRAM word address width (320x240 = 76800 words fits).
- DATA_W, 12, pixel width (RGB444).
- MAX_BURST, 8, maximum consecutive granted writes per writer ownership; legal range 1..255.
- WR_BLANK_ONLY, 1, when 1, writes are granted only while blank=1; when 0, writes are granted on any cycle without a display read.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- blank  in  1  high outside the active display region
- rd_req  in  1  display pixel fetch request, one per cycle
- rd_addr  in  ADDR_W  display fetch address
- rd_data  out  DATA_W  fetched pixel
- rd_valid  out  1  rd_data valid
- wr_req  in  2  per-writer write request (level)
- wr_addr0 / wr_addr1  in  ADDR_W  writer addresses
- wr_data0 / wr_data1  in  DATA_W  writer data
- wr_gnt  out  2  per-writer write accepted this cycle (combinational)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (asynchronous):
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - rd_valid=0, rd_data=0.
  - Read pipeline valid bits cleared, so no rd_valid is produced for reads in flight.
- Cycle priority:
  - rd_req=1 → read slot: mem_en=1, mem_we=0, mem_addr=rd_addr, wr_gnt=00, regardless of writer state.
  - Read latency is fixed at 2 cycles: a request accepted at cycle N gives rd_valid=1 with rd_data=mem_rdata at N+2. rd_data is a registered capture of mem_rdata at N+1.
  - rd_valid=0 on cycles with no matching request.
- Write eligibility: write_ok = !rd_req && (blank || !WR_BLANK_ONLY).
- State machine, states IDLE, OWN0, OWN1:
  - IDLE, write_ok, some wr_req set:
    - Pick the requester starting from rr_ptr; if both request, rr_ptr wins.
    - Grant it this cycle and move to OWNi with burst_cnt=1.
  - IDLE, write_ok=0: stay in IDLE, grant nothing.
  - OWNi, wr_req[i]=0: return to IDLE, rr_ptr=~i; the other writer may be granted the same cycle if write_ok.
  - OWNi, wr_req[i]=1, write_ok, burst_cnt<MAX_BURST: grant i, burst_cnt+1.
  - OWNi, burst_cnt==MAX_BURST:
    - If the other writer requests: switch directly to OWN(~i), grant it if write_ok, burst_cnt=1 (or 0 if not granted).
    - Otherwise: burst_cnt=0 and continue in OWNi.
  - OWNi, write_ok=0: hold state, no grant, burst_cnt unchanged. Display steals cycles without forfeiting ownership.
- On a grant: mem_en=1, mem_we=1, mem_addr=wr_addrI, mem_wdata=wr_dataI, wr_gnt[i]=1 for exactly that cycle. At most one wr_gnt bit is high per cycle.
- Writers hold address and data stable until granted. A writer deasserting req before grant is legal; no write occurs.
- Idle cycle (no read, no grant): mem_en=0, mem_we=0; mem_addr and mem_wdata drive 0.
- rr_ptr flips to the other writer after every ownership release or rotation.
- Reset asserted mid-burst: any in-flight write has already completed (single cycle). No grant appears until after reset deasserts.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- When defined, add outputs:
  - gnt_cnt0 / gnt_cnt1 (16 bits each): count writes granted per writer, saturating at 0xFFFF.
  - stall_cnt (16 bits): counts cycles with any wr_req high and no grant, saturating.
  - All three counters are cleared by reset and by a new input stats_clr (synchronous, 1 cycle).
- When undefined, these ports and all counter logic are absent.

Test Plan:
- Read latency: rd_req=1, rd_addr=0x00010, RAM preloaded with 0xABC → mem_addr=0x00010 at N, rd_valid=1 and rd_data=0xABC at N+2, with no write grant during N.
- Blank gating: WR_BLANK_ONLY=1, blank=0, rd_req=0, wr_req=01 → wr_gnt=00. Raise blank=1 → wr_gnt=01 in the same cycle, mem_we=1, mem_addr=wr_addr0.
- Round-robin and burst: MAX_BURST=4, blank=1, both writers held requesting from reset → grants 0,0,0,0,1,1,1,1,0,...
- Display steal: writer 0 owning mid-burst (burst_cnt=2), rd_req=1 for 3 cycles → wr_gnt=00 for those 3 cycles, then writer 0 resumes at burst_cnt=3 without losing ownership.
- Release: writer 0 drops wr_req after 2 grants while writer 1 requests → writer 1 granted in that same cycle, state OWN1.
- Reset mid-operation: assert reset with two reads in flight and state OWN1 → rd_valid=0 next cycle; after release, state is IDLE and the first simultaneous request is granted to writer 0.
